// File: rtl/rv32im_mem_arbiter.sv
// rv32im_mem_arbiter: shares one memory port between instruction fetch and data
// accesses, one transaction outstanding, data-first priority with fetch anti-starvation.
module rv32im_mem_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req_valid,
   input  logic [31:0] i_req_addr,
   output logic        i_req_ready,
   output logic        i_resp_valid,
   output logic [31:0] i_resp_data,
   input  logic        d_req_valid,
   input  logic [31:0] d_req_addr,
   input  logic [31:0] d_req_wdata,
   input  logic [3:0]  d_req_wstrb,
   output logic        d_req_ready,
   output logic        d_resp_valid,
   output logic [31:0] d_resp_data,
   output logic        m_req_valid,
   output logic [31:0] m_req_addr,
   output logic [31:0] m_req_wdata,
   output logic [3:0]  m_req_wstrb,
   input  logic        m_req_ready,
   input  logic        m_resp_valid,
   input  logic [31:0] m_resp_data,
   output logic        err_timeout
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
   state_t state, state_nx;
   logic [SW-1:0] starve_cnt;
   logic [TW-1:0] tcnt;
   logic owner_i, i_pulse, d_pulse, err_pulse;
   logic [31:0] lat_addr, lat_wdata, i_data, d_data;
   logic [3:0] lat_wstrb;
   logic idle, fetch_wins, accept, done, expire;
   always_comb begin
      idle = state == IDLE && !rst;
      fetch_wins = i_req_valid && (!d_req_valid || starve_cnt == SW'(STARVE_LIMIT));
      i_req_ready = idle && fetch_wins;
      d_req_ready = idle && d_req_valid && !fetch_wins;
      accept = i_req_ready || d_req_ready;
      done = state == RESP && m_resp_valid;
      // tcnt lags the accept by one cycle and the pulse is registered, so fire two early
      expire = state != IDLE && tcnt == TW'(TIMEOUT - 2) && !done;
      state_nx = state;
      if (state == IDLE && accept) state_nx = REQ;
      if (state == REQ && m_req_ready) state_nx = RESP;
      if (done || expire) state_nx = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         starve_cnt <= '0;
         tcnt <= '0;
         owner_i <= 1'b0;
         lat_addr <= '0;
         lat_wdata <= '0;
         lat_wstrb <= '0;
         i_data <= '0;
         d_data <= '0;
         i_pulse <= 1'b0;
         d_pulse <= 1'b0;
         err_pulse <= 1'b0;
      end else begin
         state <= state_nx;
         tcnt <= accept ? '0 : state != IDLE ? tcnt + 1'b1 : tcnt;
         if (accept) begin
            owner_i <= i_req_ready;
            lat_addr <= i_req_ready ? i_req_addr : d_req_addr;
            lat_wdata <= i_req_ready ? '0 : d_req_wdata;
            lat_wstrb <= i_req_ready ? '0 : d_req_wstrb;
            starve_cnt <= i_req_ready ? '0 :
               (i_req_valid && starve_cnt != SW'(STARVE_LIMIT)) ? starve_cnt + 1'b1 : starve_cnt;
         end
         i_pulse <= (done || expire) && owner_i;
         d_pulse <= (done || expire) && !owner_i;
         err_pulse <= expire;
         if ((done || expire) && owner_i) i_data <= done ? m_resp_data : '0;
         if ((done || expire) && !owner_i) d_data <= done ? m_resp_data : '0;
      end
   end
   // outputs forced low combinationally while rst is high
   assign m_req_valid = !rst && state == REQ;
   assign m_req_addr = rst ? '0 : lat_addr;
   assign m_req_wdata = rst ? '0 : lat_wdata;
   assign m_req_wstrb = rst ? '0 : lat_wstrb;
   assign i_resp_valid = !rst && i_pulse;
   assign d_resp_valid = !rst && d_pulse;
   assign i_resp_data = rst ? '0 : i_data;
   assign d_resp_data = rst ? '0 : d_data;
   assign err_timeout = !rst && err_pulse;
endmodule

// File: tb/tb_rv32im_mem_arbiter.sv
// tb_rv32im_mem_arbiter: directed scenarios checked every cycle against a
// transaction-level model, plus hand-computed literal expectations.
module tb_rv32im_mem_arbiter;
   localparam int STARVE_LIMIT = 4;
   localparam int TIMEOUT = 255;
   logic clk = 1'b0, rst = 1'b1;
   logic i_req_valid = 1'b0, d_req_valid = 1'b0, m_req_ready = 1'b0, m_resp_valid = 1'b0;
   logic [31:0] i_req_addr = '0, d_req_addr = '0, d_req_wdata = '0, m_resp_data = '0;
   logic [3:0] d_req_wstrb = '0;
   logic i_req_ready, i_resp_valid, d_req_ready, d_resp_valid, m_req_valid, err_timeout;
   logic [31:0] i_resp_data, d_resp_data, m_req_addr, m_req_wdata;
   logic [3:0] m_req_wstrb;
   int nvec = 0, nfail = 0;
   rv32im_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
      .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
      .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
      .d_req_wstrb(d_req_wstrb), .d_req_ready(d_req_ready),
      .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
      .m_req_valid(m_req_valid), .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata),
      .m_req_wstrb(m_req_wstrb), .m_req_ready(m_req_ready),
      .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data), .err_timeout(err_timeout)
   );
   always #5 clk = ~clk;
   // model: the one pending transaction, its age in cycles since accept, whether memory took it
   logic busy = 1'b0, own_i = 1'b0, acked = 1'b0, pi = 1'b0, pd = 1'b0, perr = 1'b0;
   logic [31:0] ma = '0, mw = '0, li = '0, ld = '0;
   logic [3:0] ms = '0;
   int age = 0, starve = 0;
   logic fw;
   assign fw = i_req_valid && (!d_req_valid || starve == STARVE_LIMIT);
   always @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0; starve <= 0; pi <= 1'b0; pd <= 1'b0; perr <= 1'b0; li <= '0; ld <= '0;
      end else begin
         pi <= 1'b0; pd <= 1'b0; perr <= 1'b0;
         if (busy) begin
            if ((acked && m_resp_valid) || age + 1 == TIMEOUT) begin
               busy <= 1'b0;
               pi <= own_i;
               pd <= !own_i;
               perr <= !(acked && m_resp_valid);
               if (own_i) li <= (acked && m_resp_valid) ? m_resp_data : 32'h0;
               else ld <= (acked && m_resp_valid) ? m_resp_data : 32'h0;
            end else begin
               age <= age + 1;
               if (m_req_ready) acked <= 1'b1;
            end
         end else if (i_req_valid || d_req_valid) begin
            busy <= 1'b1; acked <= 1'b0; age <= 1; own_i <= fw;
            ma <= fw ? i_req_addr : d_req_addr;
            mw <= fw ? 32'h0 : d_req_wdata;
            ms <= fw ? 4'h0 : d_req_wstrb;
            starve <= fw ? 0 : (i_req_valid && starve < STARVE_LIMIT) ? starve + 1 : starve;
         end
      end
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic cmp();
      chk("i_req_ready", {31'b0, i_req_ready}, {31'b0, !rst && !busy && fw});
      chk("d_req_ready", {31'b0, d_req_ready}, {31'b0, !rst && !busy && d_req_valid && !fw});
      chk("m_req_valid", {31'b0, m_req_valid}, {31'b0, !rst && busy && !acked});
      if (rst || (busy && !acked)) begin
         chk("m_req_addr", m_req_addr, rst ? 32'h0 : ma);
         chk("m_req_wdata", m_req_wdata, rst ? 32'h0 : mw);
         chk("m_req_wstrb", {28'b0, m_req_wstrb}, rst ? 32'h0 : {28'b0, ms});
      end
      chk("i_resp_valid", {31'b0, i_resp_valid}, {31'b0, !rst && pi});
      chk("i_resp_data", i_resp_data, rst ? 32'h0 : li);
      chk("d_resp_valid", {31'b0, d_resp_valid}, {31'b0, !rst && pd});
      chk("d_resp_data", d_resp_data, rst ? 32'h0 : ld);
      chk("err_timeout", {31'b0, err_timeout}, {31'b0, !rst && perr});
   endtask
   task automatic samp();
      @(negedge clk);
      cmp();
   endtask
   task automatic adv();
      @(posedge clk);
      #1;
   endtask
   task automatic cyc();
      samp();
      adv();
   endtask
   initial begin
      int g, c;
      logic [9:0] order;
      adv();
      i_req_valid = 1'b1;
      samp(); chk("ready low in rst", {31'b0, i_req_ready}, 32'h0); adv();
      cyc();
      // single fetch, zero-wait memory
      rst = 1'b0; m_req_ready = 1'b1; m_resp_valid = 1'b1; m_resp_data = 32'h13;
      i_req_addr = 32'h100;
      samp(); chk("fetch ready c0", {31'b0, i_req_ready}, 32'h1); adv();
      i_req_valid = 1'b0;
      samp(); chk("m_req_valid c1", {31'b0, m_req_valid}, 32'h1);
      chk("m_req_addr c1", m_req_addr, 32'h100); adv();
      cyc();
      samp(); chk("i_resp_valid c3", {31'b0, i_resp_valid}, 32'h1);
      chk("i_resp_data c3", i_resp_data, 32'h13); adv();
      // continuous contention: fetch gets in after four data grants
      i_req_valid = 1'b1; i_req_addr = 32'h80;
      d_req_valid = 1'b1; d_req_addr = 32'h40; d_req_wdata = '0; d_req_wstrb = '0;
      m_resp_data = 32'h77; g = 0; order = '0;
      for (int k = 0; k < 40 && g < 10; k++) begin
         samp();
         if (i_req_ready || d_req_ready) begin
            order[9-g] = i_req_ready;
            g++;
         end
         adv();
      end
      i_req_valid = 1'b0; d_req_valid = 1'b0;
      chk("grant count", g, 10);
      chk("grant order", {22'b0, order}, 32'b0000100001);
      for (int k = 0; k < 3; k++) cyc();
      // store held in REQ for five cycles, stray response in REQ ignored
      m_req_ready = 1'b0; m_resp_valid = 1'b0;
      d_req_valid = 1'b1; d_req_addr = 32'h200; d_req_wdata = 32'hDEADBEEF; d_req_wstrb = 4'hF;
      samp(); chk("store ready", {31'b0, d_req_ready}, 32'h1); adv();
      d_req_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         m_resp_valid = k == 2;
         samp();
         chk("store m_req_valid", {31'b0, m_req_valid}, 32'h1);
         chk("store addr", m_req_addr, 32'h200);
         chk("store wdata", m_req_wdata, 32'hDEADBEEF);
         chk("store wstrb", {28'b0, m_req_wstrb}, 32'hF);
         adv();
      end
      m_resp_valid = 1'b0; m_req_ready = 1'b1;
      cyc();
      m_req_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         samp(); chk("store no early resp", {31'b0, d_resp_valid}, 32'h0); adv();
      end
      m_resp_valid = 1'b1; m_resp_data = 32'h12345678;
      cyc();
      m_resp_valid = 1'b0;
      samp(); chk("store resp valid", {31'b0, d_resp_valid}, 32'h1);
      chk("store resp data", d_resp_data, 32'h12345678); adv();
      // stray response while idle
      m_resp_valid = 1'b1; m_resp_data = 32'hBAD;
      for (int k = 0; k < 2; k++) begin
         samp(); chk("stray i", {31'b0, i_resp_valid}, 32'h0);
         chk("stray d", {31'b0, d_resp_valid}, 32'h0); adv();
      end
      m_resp_valid = 1'b0;
      // memory never answers
      m_req_ready = 1'b1; d_req_valid = 1'b1; d_req_addr = 32'h300; d_req_wstrb = 4'h0;
      samp(); chk("timeout accept", {31'b0, d_req_ready}, 32'h1); adv();
      d_req_valid = 1'b0; c = 0;
      for (int k = 1; k <= 300; k++) begin
         samp();
         if (err_timeout) begin
            c = k;
            chk("timeout resp valid", {31'b0, d_resp_valid}, 32'h1);
            chk("timeout resp data", d_resp_data, 32'h0);
            adv();
            break;
         end
         adv();
      end
      chk("timeout cycle", c, TIMEOUT);
      // back in IDLE; response arriving on the expiry cycle beats the timeout
      d_req_valid = 1'b1; d_req_addr = 32'h304;
      samp(); chk("idle after timeout", {31'b0, d_req_ready}, 32'h1); adv();
      d_req_valid = 1'b0;
      for (int k = 1; k <= 253; k++) cyc();
      m_resp_valid = 1'b1; m_resp_data = 32'hA5A5A5A5;
      cyc();
      m_resp_valid = 1'b0;
      samp(); chk("late resp valid", {31'b0, d_resp_valid}, 32'h1);
      chk("late resp data", d_resp_data, 32'hA5A5A5A5);
      chk("late resp no err", {31'b0, err_timeout}, 32'h0); adv();
      // reset in RESP abandons the fetch
      i_req_valid = 1'b1; i_req_addr = 32'h400;
      samp(); chk("pre-rst accept", {31'b0, i_req_ready}, 32'h1); adv();
      i_req_valid = 1'b0;
      cyc();
      rst = 1'b1;
      samp(); chk("rst m_req_valid", {31'b0, m_req_valid}, 32'h0); adv();
      rst = 1'b0; m_resp_valid = 1'b1; m_resp_data = 32'h99;
      for (int k = 0; k < 3; k++) begin
         samp(); chk("no resp after rst", {31'b0, i_resp_valid}, 32'h0); adv();
      end
      i_req_valid = 1'b1; i_req_addr = 32'h500; m_resp_data = 32'h55;
      samp(); chk("post-rst accept", {31'b0, i_req_ready}, 32'h1); adv();
      i_req_valid = 1'b0;
      cyc();
      cyc();
      samp(); chk("post-rst resp", {31'b0, i_resp_valid}, 32'h1);
      chk("post-rst data", i_resp_data, 32'h55); adv();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule

// File: doc/rv32im_mem_arbiter.md
RV32IM_MEM_ARBITER -- requirements
Module: rv32im_mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive data grants while a fetch waits.
REQ-002 Parameter TIMEOUT, default 255: cycles allowed from grant to memory response.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 i_req_valid  in  1  fetch request valid.
REQ-006 i_req_addr  in  32  fetch byte address.
REQ-007 i_req_ready  out  1  fetch request accepted this cycle.
REQ-008 i_resp_valid  out  1  fetch response pulse.
REQ-009 i_resp_data  out  32  fetch response data.
REQ-010 d_req_valid  in  1  data request valid.
REQ-011 d_req_addr  in  32  data byte address.
REQ-012 d_req_wdata  in  32  store data.
REQ-013 d_req_wstrb  in  4  byte strobes, 0 = load.
REQ-014 d_req_ready  out  1  data request accepted this cycle.
REQ-015 d_resp_valid  out  1  data response pulse.
REQ-016 d_resp_data  out  32  data response data.
REQ-017 m_req_valid  out  1  shared memory request valid.
REQ-018 m_req_addr / m_req_wdata / m_req_wstrb  out  32/32/4  shared memory request fields.
REQ-019 m_req_ready  in  1  memory accepts request.
REQ-020 m_resp_valid  in  1  memory response valid; m_resp_data  in  32  response data.
REQ-021 err_timeout  out  1  one-cycle pulse on transaction timeout.

Function
REQ-022 FSM states IDLE, REQ, RESP; one transaction outstanding at a time.
REQ-023 IDLE: winner chosen combinationally; winner's x_req_ready = x_req_valid, loser's ready = 0; readies are 0 in REQ and RESP.
REQ-024 Priority: data wins, except fetch wins when both valid and starve_cnt == STARVE_LIMIT.
REQ-025 starve_cnt: +1 (saturating at STARVE_LIMIT) on data grant with i_req_valid high; cleared on fetch grant; unchanged otherwise.
REQ-026 On accept: latch owner, addr, wdata, wstrb (wdata = 0, wstrb = 0 for fetch); go REQ next cycle.
REQ-027 REQ: m_req_valid = 1, fields from latched copy, stable until m_req_ready; m_req_ready high -> RESP next cycle.
REQ-028 RESP: m_resp_valid high -> owner's resp_valid pulses 1 cycle next cycle, resp_data = registered m_resp_data; go IDLE.
REQ-029 Stores also wait for m_resp_valid; response data forwarded unmodified.
REQ-030 m_resp_valid outside RESP ignored; m_req_ready outside REQ ignored.
REQ-031 Non-owner resp_valid never asserts; resp_data holds last value when resp_valid = 0.
REQ-032 Timeout counter cleared on accept, increments each cycle in REQ/RESP; reaching TIMEOUT -> owner resp_valid pulse with data 0x00000000, err_timeout pulse same cycle, go IDLE.
REQ-033 m_resp_valid in the same cycle as timeout expiry: real response wins, no err_timeout.
REQ-034 Best-case throughput: accept, 1 cycle REQ, 1 cycle RESP, response -> one transaction per 3 cycles; latency accept-to-resp_valid = 3 cycles with zero memory wait.

Reset
REQ-035 rst high at a clock edge: state IDLE, starve_cnt 0, timeout counter 0, owner cleared, all outputs 0 (including readies, the same cycle rst is high).
REQ-036 rst mid-transaction abandons it with no response pulse; a late m_resp_valid after reset is ignored.

Verification
REQ-037 Fetch only, addr 0x100, memory ready and response 0x00000013 immediate -> i_req_ready cycle 0, m_req_addr 0x100 cycle 1, i_resp_valid with 0x00000013 cycle 3.
REQ-038 Both valid continuously, STARVE_LIMIT 4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-039 Store addr 0x200, wdata 0xDEADBEEF, wstrb 0xF, m_req_ready low 5 cycles -> m_req fields stable all 5 cycles, d_resp_valid only after m_resp_valid.
REQ-040 Memory never responds, TIMEOUT 255 -> err_timeout and d_resp_valid with data 0 exactly 255 cycles after accept, FSM back to IDLE.
REQ-041 rst asserted in RESP, then m_resp_valid -> no resp_valid pulses, all outputs 0, next fetch served normally.
REQ-042 Stray m_resp_valid in IDLE -> no response pulse, no state change.
